// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Serializes the IF-stage fetch and MEM-stage data SRAM-style requests onto
// one request/addr_ok/data_ok bus port. The data access goes first, then the
// fetch. stallreq holds the pipeline until both accesses of the current
// pipeline cycle have completed.
//
// Optional feature macro: ARB_WRITE_NOWAIT_EN
//   defined   : a write completes at mem_addr_ok and its data phase is skipped
//   undefined : a write waits for mem_data_ok exactly like a read
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | waiting for a pipeline request; payload is loaded on the way out
// D_ADDR | data request on the bus, waiting for mem_addr_ok
// D_DATA | data request accepted, waiting for mem_data_ok
// I_ADDR | fetch request on the bus, waiting for mem_addr_ok (flush aborts)
// I_DATA | fetch request accepted, waiting for mem_data_ok
// DONE   | one cycle with stallreq low; hold registers drive the rdata ports

module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  inst_sram_en,
  input  logic [DATA_W/8-1:0]   inst_sram_wen,
  input  logic [ADDR_W-1:0]     inst_sram_addr,
  input  logic [DATA_W-1:0]     inst_sram_wdata,
  output logic [DATA_W-1:0]     inst_sram_rdata,

  input  logic                  data_sram_en,
  input  logic [DATA_W/8-1:0]   data_sram_wen,
  input  logic [ADDR_W-1:0]     data_sram_addr,
  input  logic [DATA_W-1:0]     data_sram_wdata,
  output logic [DATA_W-1:0]     data_sram_rdata,

  input  logic                  flush,
  output logic                  stallreq,

  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_addr_ok,
  input  logic                  mem_data_ok,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_ADDR = 3'd1,
    D_DATA = 3'd2,
    I_ADDR = 3'd3,
    I_DATA = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t              state;
  logic                cancel;
  logic [DATA_W-1:0]   inst_hold;
  logic [DATA_W-1:0]   data_hold;

  logic                pick_wr;
  logic [STRB_W-1:0]   pick_wen;
  logic [ADDR_W-1:0]   pick_addr;
  logic [DATA_W-1:0]   pick_wdata;
  logic                inst_next;

  assign inst_sram_rdata = inst_hold;
  assign data_sram_rdata = data_hold;

  // A fetch still goes out after the data access only if no cancel is pending,
  // including a flush arriving in the very cycle the decision is made.
  assign inst_next = inst_sram_en & ~cancel & ~flush;

  // Payload to load into the bus registers: data side only when leaving IDLE
  // with a data request, otherwise the fetch side.
  always_comb begin
    if (state == IDLE && data_sram_en) begin
      pick_wen   = data_sram_wen;
      pick_addr  = data_sram_addr;
      pick_wdata = data_sram_wdata;
    end else begin
      pick_wen   = inst_sram_wen;
      pick_addr  = inst_sram_addr;
      pick_wdata = inst_sram_wdata;
    end
    pick_wr = |pick_wen;
  end

  // Stall while any access of the current pipeline cycle is outstanding.
  always_comb begin
    stallreq = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    stallreq = inst_sram_en | data_sram_en;
        DONE:    stallreq = 1'b0;
        default: stallreq = 1'b1;
      endcase
    end
  end

  // Arbiter FSM with registered bus outputs, cancel flag and hold registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cancel    <= 1'b0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      inst_hold <= '0;
      data_hold <= '0;
    end else begin
      case (state)
        IDLE: begin
          cancel <= 1'b0;
          if (data_sram_en) begin
            state     <= D_ADDR;
            cancel    <= flush;
            mem_req   <= 1'b1;
            mem_wr    <= pick_wr;
            mem_wstrb <= pick_wen;
            mem_addr  <= pick_addr;
            mem_wdata <= pick_wdata;
          end else if (inst_sram_en) begin
            if (flush) begin
              // Fetch cancelled before it ever reached the bus.
              state     <= DONE;
              inst_hold <= '0;
            end else begin
              state     <= I_ADDR;
              mem_req   <= 1'b1;
              mem_wr    <= pick_wr;
              mem_wstrb <= pick_wen;
              mem_addr  <= pick_addr;
              mem_wdata <= pick_wdata;
            end
          end
        end

        D_ADDR: begin
          if (flush) cancel <= 1'b1;
          if (mem_addr_ok) begin
`ifdef ARB_WRITE_NOWAIT_EN
            if (mem_wr) begin
              data_hold <= '0;
              if (inst_next) begin
                // Back-to-back: mem_req stays high with the fetch payload.
                state     <= I_ADDR;
                mem_wr    <= pick_wr;
                mem_wstrb <= pick_wen;
                mem_addr  <= pick_addr;
                mem_wdata <= pick_wdata;
              end else begin
                state   <= DONE;
                mem_req <= 1'b0;
                if (inst_sram_en) inst_hold <= '0;
              end
            end else begin
              state   <= D_DATA;
              mem_req <= 1'b0;
            end
`else
            state   <= D_DATA;
            mem_req <= 1'b0;
`endif
          end
        end

        D_DATA: begin
          if (flush) cancel <= 1'b1;
          if (mem_data_ok) begin
            data_hold <= mem_wr ? '0 : mem_rdata;
            if (inst_next) begin
              state     <= I_ADDR;
              mem_req   <= 1'b1;
              mem_wr    <= pick_wr;
              mem_wstrb <= pick_wen;
              mem_addr  <= pick_addr;
              mem_wdata <= pick_wdata;
            end else begin
              state <= DONE;
              if (inst_sram_en) inst_hold <= '0;
            end
          end
        end

        I_ADDR: begin
          if (mem_addr_ok) begin
            // Acceptance wins over a coincident flush; the response is
            // then discarded in I_DATA.
            mem_req <= 1'b0;
            if (flush) cancel <= 1'b1;
`ifdef ARB_WRITE_NOWAIT_EN
            if (mem_wr) begin
              state     <= DONE;
              inst_hold <= '0;
            end else begin
              state <= I_DATA;
            end
`else
            state <= I_DATA;
`endif
          end else if (flush) begin
            state     <= DONE;
            mem_req   <= 1'b0;
            cancel    <= 1'b1;
            inst_hold <= '0;
          end
        end

        I_DATA: begin
          if (flush) cancel <= 1'b1;
          if (mem_data_ok) begin
            inst_hold <= (mem_wr | cancel | flush) ? '0 : mem_rdata;
            state     <= DONE;
          end
        end

        DONE: begin
          state  <= IDLE;
          cancel <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          cancel  <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: scoreboard of expected bus requests and
// expected DONE results, a randomized bus responder, and a monitor that checks
// the DUT whenever it presents a bus handshake or completes a pipeline cycle.

module tb_mem_port_arbiter;

`ifdef ARB_WRITE_NOWAIT_EN
  localparam bit NOWAIT = 1'b1;
`else
  localparam bit NOWAIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        flush;
  logic        stallreq;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .flush           (flush),
    .stallreq        (stallreq),
    .mem_req         (mem_req),
    .mem_wr          (mem_wr),
    .mem_wstrb       (mem_wstrb),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_addr_ok     (mem_addr_ok),
    .mem_data_ok     (mem_data_ok),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          adly;
    int          ddly;
    logic [31:0] rdata;
    bit          no_rsp;
  } rsp_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] data;
    int          stall;
  } res_t;

  req_t exp_req_q[$];
  rsp_t rsp_q[$];
  res_t res_q[$];

  int vectors = 0;
  int errors  = 0;
  int issued_cnt = 0;
  int done_cnt   = 0;
  bit expect_quiet = 1'b0;

  logic [31:0] m_inst = 32'h0;
  logic [31:0] m_data = 32'h0;

  // Bus responder: accepts each request after adly cycles, answers adly/ddly
  // as popped from rsp_q; abandons a request whose mem_req disappears.
  int   rs  = 0;
  int   cnt = 0;
  rsp_t cur;
  initial begin
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
    forever begin
      @(posedge clk); #1;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      if (rs == 0 && mem_req === 1'b1 && !rst) begin
        if (rsp_q.size() > 0) cur = rsp_q.pop_front();
        else cur = '{adly: 0, ddly: 0, rdata: 32'h0, no_rsp: 1'b0};
        cnt = cur.adly;
        rs  = 1;
      end else if (rs == 1 && mem_req !== 1'b1) begin
        rs = 0;
      end
      if (rs == 1) begin
        if (cnt == 0) begin
          mem_addr_ok = 1'b1;
          cnt = cur.ddly;
          rs  = cur.no_rsp ? 0 : 2;
        end else cnt--;
      end else if (rs == 2) begin
        if (cnt == 0) begin
          mem_data_ok = 1'b1;
          mem_rdata   = cur.rdata;
          rs = 0;
        end else cnt--;
      end
    end
  end

  // Monitor: checks every bus handshake and every DONE cycle against the
  // scoreboard queues, plus quiet outputs after reset.
  int   stall_cnt = 0;
  req_t er;
  res_t eres;
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req && mem_addr_ok && !rst) begin
        vectors++;
        if (exp_req_q.size() == 0) begin
          errors++;
          $display("FAIL bus_req_unexpected: got addr=%h wr=%b, required no request", mem_addr, mem_wr);
        end else begin
          er = exp_req_q.pop_front();
          if (mem_addr !== er.addr || mem_wr !== er.wr || mem_wstrb !== er.wstrb || mem_wdata !== er.wdata) begin
            errors++;
            $display("FAIL bus_req: got addr=%h wr=%b strb=%b wdata=%h, required addr=%h wr=%b strb=%b wdata=%h",
                     mem_addr, mem_wr, mem_wstrb, mem_wdata, er.addr, er.wr, er.wstrb, er.wdata);
          end
        end
      end
      if (expect_quiet) begin
        vectors++;
        if (stallreq !== 1'b0 || mem_req !== 1'b0 || mem_wr !== 1'b0 || mem_wstrb !== 4'h0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || inst_sram_rdata !== 32'h0 || data_sram_rdata !== 32'h0) begin
          errors++;
          $display("FAIL reset_quiet: got stall=%b req=%b wr=%b strb=%h addr=%h wdata=%h irdata=%h drdata=%h, required all 0",
                   stallreq, mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, inst_sram_rdata, data_sram_rdata);
        end
      end
      if (done_cnt < issued_cnt) begin
        if (stallreq === 1'b1) begin
          stall_cnt++;
          if (stall_cnt > 300) begin
            vectors++;
            errors++;
            $display("FAIL done_timeout: got no DONE after %0d stall cycles, required DONE", stall_cnt);
            void'(res_q.pop_front());
            done_cnt++;
            stall_cnt = 0;
          end
        end else begin
          eres = res_q.pop_front();
          vectors++;
          if (inst_sram_rdata !== eres.inst || data_sram_rdata !== eres.data ||
              stall_cnt != eres.stall || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL done_result: got inst=%h data=%h stalls=%0d req=%b, required inst=%h data=%h stalls=%0d req=0",
                     inst_sram_rdata, data_sram_rdata, stall_cnt, mem_req, eres.inst, eres.data, eres.stall);
          end
          done_cnt++;
          stall_cnt = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    @(posedge clk); #1;
    inst_sram_en = 1'b0;
    data_sram_en = 1'b0;
    flush        = 1'b0;
  endtask

  // One pipeline cycle: data and/or fetch request, with bus delays per access.
  task automatic issue(input bit de, input logic [3:0] dw, input logic [31:0] da,
                       input logic [31:0] dwd, input logic [31:0] drd, input int dad, input int ddd,
                       input bit ie, input logic [3:0] iw, input logic [31:0] ia,
                       input logic [31:0] iwd, input logic [31:0] ird, input int iad, input int idd);
    res_t r;
    @(posedge clk); #1;
    data_sram_en = de; data_sram_wen = dw; data_sram_addr = da; data_sram_wdata = dwd;
    inst_sram_en = ie; inst_sram_wen = iw; inst_sram_addr = ia; inst_sram_wdata = iwd;
    flush = 1'b0;
    r.stall = 1;
    if (de) begin
      exp_req_q.push_back('{addr: da, wr: |dw, wstrb: dw, wdata: dwd});
      rsp_q.push_back('{adly: dad, ddly: ddd, rdata: drd, no_rsp: (|dw) && NOWAIT});
      r.stall += ((|dw) && NOWAIT) ? dad + 1 : dad + ddd + 2;
      m_data = (|dw) ? 32'h0 : drd;
    end
    if (ie) begin
      exp_req_q.push_back('{addr: ia, wr: |iw, wstrb: iw, wdata: iwd});
      rsp_q.push_back('{adly: iad, ddly: idd, rdata: ird, no_rsp: (|iw) && NOWAIT});
      r.stall += ((|iw) && NOWAIT) ? iad + 1 : iad + idd + 2;
      m_inst = (|iw) ? 32'h0 : ird;
    end
    r.inst = m_inst;
    r.data = m_data;
    res_q.push_back(r);
    issued_cnt++;
    wait (done_cnt == issued_cnt);
  endtask

  initial begin
    res_t r;
    logic [3:0] dw, iw;
    rst = 1'b1;
    flush = 1'b0;
    inst_sram_en = 1'b0; inst_sram_wen = 4'h0; inst_sram_addr = 32'h0; inst_sram_wdata = 32'h0;
    data_sram_en = 1'b0; data_sram_wen = 4'h0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
    @(posedge clk); #1;
    expect_quiet = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    expect_quiet = 1'b0;

    // Fetch-only on a zero-wait bus.
    issue(0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 0,
          1, 4'h0, 32'hbfc00000, 32'h0, 32'h24080001, 0, 0);
    idle();
    // Data load and fetch in the same pipeline cycle.
    issue(1, 4'h0, 32'h80000010, 32'h0, 32'h11223344, 0, 1,
          1, 4'h0, 32'hbfc00004, 32'h0, 32'h3c1d8001, 1, 0);
    // Store with partial strobes.
    issue(1, 4'b0011, 32'h80000020, 32'hdeadbeef, 32'h55555555, 1, 2,
          0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 0);
    idle();

    // Flush in I_ADDR while addr_ok is held low.
    @(posedge clk); #1;
    inst_sram_en = 1'b1; inst_sram_wen = 4'h0; inst_sram_addr = 32'hbfc00008;
    rsp_q.push_back('{adly: 50, ddly: 0, rdata: 32'h0badf00d, no_rsp: 1'b0});
    m_inst = 32'h0;
    r = '{inst: m_inst, data: m_data, stall: 3};
    res_q.push_back(r);
    issued_cnt++;
    @(posedge clk); #1;
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    wait (done_cnt == issued_cnt);
    idle();

    // Flush in I_DATA; the late response is discarded.
    @(posedge clk); #1;
    inst_sram_en = 1'b1; inst_sram_wen = 4'h0; inst_sram_addr = 32'hbfc0000c; inst_sram_wdata = 32'h0;
    exp_req_q.push_back('{addr: 32'hbfc0000c, wr: 1'b0, wstrb: 4'h0, wdata: 32'h0});
    rsp_q.push_back('{adly: 0, ddly: 3, rdata: 32'h12345678, no_rsp: 1'b0});
    m_inst = 32'h0;
    r = '{inst: m_inst, data: m_data, stall: 6};
    res_q.push_back(r);
    issued_cnt++;
    @(posedge clk); #1;
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    wait (done_cnt == issued_cnt);
    idle();

    // Reset asserted in D_DATA, then a stray data_ok.
    @(posedge clk); #1;
    data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = 32'h80000030; data_sram_wdata = 32'h0;
    exp_req_q.push_back('{addr: 32'h80000030, wr: 1'b0, wstrb: 4'h0, wdata: 32'h0});
    rsp_q.push_back('{adly: 0, ddly: 3, rdata: 32'hcafef00d, no_rsp: 1'b0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1; data_sram_en = 1'b0;
    @(posedge clk); #1; rst = 1'b0; expect_quiet = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    expect_quiet = 1'b0;
    m_inst = 32'h0;
    m_data = 32'h0;

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      bit de, ie;
      de = 1'($urandom_range(0, 1));
      ie = 1'($urandom_range(0, 1));
      if (!de && !ie) ie = 1'b1;
      dw = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      iw = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      issue(de, dw, {$urandom} & 32'hfffffffc, $urandom, $urandom,
            int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
            ie, iw, {$urandom} & 32'hfffffffc, $urandom, $urandom,
            int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    repeat (5) @(posedge clk);
    #1;
    if (exp_req_q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL bus_req_missing: got %0d requests never issued, required 0", exp_req_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one unified memory port between the IF-stage instruction fetch interface and the MEM-stage data interface. The arbiter accepts the pipeline's single-cycle SRAM-style requests, which are enable, byte-write-enable, address and write data. It serializes them onto a request/address-ok/data-ok handshake bus, data first and then instruction. It holds the pipeline through `stallreq` until both accesses of the current pipeline cycle complete. It sits between the IF/MEM stages and the external bus bridge, and its `stallreq` feeds the stall controller.

## Interface
- `ADDR_W`, default 32: address width of all ports.
- `DATA_W`, default 32: data width of all ports; byte strobes are `DATA_W/8`.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `inst_sram_en` in 1: fetch request valid.
- `inst_sram_wen` in 4: byte write enables; any nonzero value makes it a write.
- `inst_sram_addr` in ADDR_W: fetch address.
- `inst_sram_wdata` in DATA_W: write data.
- `inst_sram_rdata` out DATA_W: fetched instruction, valid in the DONE cycle.
- `data_sram_en`, `data_sram_wen`, `data_sram_addr`, `data_sram_wdata`: same as the inst_* inputs, for the data side.
- `data_sram_rdata` out DATA_W: load data, valid in the DONE cycle.
- `flush` in 1: cancels the pending instruction access.
- `stallreq` out 1: high while the current pipeline cycle's accesses are incomplete.
- `mem_req` out 1: bus request valid.
- `mem_wr` out 1: 1 for a write.
- `mem_wstrb` out 4: byte strobes.
- `mem_addr` out ADDR_W: bus address.
- `mem_wdata` out DATA_W: bus write data.
- `mem_addr_ok` in 1: request accepted this cycle.
- `mem_data_ok` in 1: response or write completion this cycle.
- `mem_rdata` in DATA_W: read data, valid with `mem_data_ok`.

## Operation
- **States:** IDLE, D_ADDR, D_DATA, I_ADDR, I_DATA, DONE. State and all `mem_*` outputs are registered.
- **Requester contract:** while `stallreq`=1, the requesters hold en, wen, addr and wdata stable.
- **IDLE:**
  - `stallreq` = `inst_sram_en | data_sram_en`.
  - If `data_sram_en`, go to D_ADDR. Otherwise, if `inst_sram_en`, go to I_ADDR.
  - In the same cycle, load the `mem_*` outputs from the selected requester and set `mem_req`=1.
- **D_ADDR / I_ADDR:**
  - `mem_req` and the payload stay stable until `mem_addr_ok`=1.
  - On `mem_addr_ok`, drop `mem_req` next cycle and go to D_DATA / I_DATA.
- **D_DATA:**
  - On `mem_data_ok`, capture `mem_rdata` into the data hold register (writes capture 0).
  - Then go to I_ADDR if `inst_sram_en` and no cancel is latched, else go to DONE.
- **I_DATA:**
  - On `mem_data_ok`, capture `mem_rdata` into the inst hold register, unless the access was cancelled, in which case capture 0.
  - Then go to DONE.
- **DONE:**
  - `stallreq`=0 for exactly one cycle; both rdata outputs present the hold registers.
  - Return to IDLE.
  - Hold registers retain their values until next overwritten.
- **Flush:**
  - In IDLE, D_ADDR or D_DATA, a `flush` latches a cancel flag; the instruction access is then skipped.
  - In I_ADDR before `addr_ok`, `flush` drops `mem_req` next cycle and goes to DONE. If `addr_ok` and `flush` coincide, the request counts as accepted: go to I_DATA and discard the response.
  - In I_DATA, `flush` latches cancel; the arbiter still waits for `mem_data_ok`.
  - The cancel flag clears on entering IDLE.
- **Data side:** never cancelled by `flush`.
- **Outstanding limit:** at most one outstanding bus transaction. `mem_data_ok` outside D_DATA/I_DATA is ignored.

## Timing
- **Reset values:** state IDLE. `mem_req`, `mem_wr`, `mem_wstrb`, `mem_addr`, `mem_wdata`, both rdata outputs and the cancel flag are 0. `stallreq` is forced to 0 while `rst`=1.
- **Reset mid-operation:** returns to IDLE next cycle. A late `mem_data_ok` is ignored.
- **Fetch-only, zero-wait bus:**
  - cycle 0: IDLE, en seen.
  - cycle 1: I_ADDR with `addr_ok`.
  - cycle 2: I_DATA with `data_ok`.
  - cycle 3: DONE.
  - Result: three stall cycles, then one cycle with `stallreq`=0.
- **Fetch plus data:** minimum five stall cycles before DONE.
- **Bus timing:** `mem_data_ok` is never expected in the same cycle as `mem_addr_ok` of the same access; its earliest arrival is the next cycle.

## Configuration
- **`ARB_WRITE_NOWAIT_EN` defined:** a write completes at `mem_addr_ok`. The arbiter goes from D_ADDR/I_ADDR directly to the next access or DONE, skipping D_DATA/I_DATA. `mem_data_ok` for writes is ignored; the bus guarantees ordering.
- **Macro undefined:** writes wait for `mem_data_ok` exactly like reads.

## Test plan
- **Inst read:** `inst_sram_en`=1, addr 0xbfc00000, `addr_ok` at cycle 1, `data_ok` at cycle 2 with rdata 0x24080001 -> `stallreq` high cycles 0-2, DONE at cycle 3 with `inst_sram_rdata`=0x24080001.
- **Data then inst:** data load at 0x80000010 and fetch at 0xbfc00004 together -> bus sees the data address first, then the inst address. Both rdata values are valid in the same DONE cycle.
- **Flush before acceptance:** `flush` in I_ADDR with `addr_ok` held low -> `mem_req` drops the next cycle, DONE follows, `inst_sram_rdata`=0.
- **Flush after acceptance:** `flush` in I_DATA, `data_ok` 3 cycles later with 0x12345678 -> `inst_sram_rdata`=0, no extra bus request.
- **Store, wstrb 4'b0011, data 0xdeadbeef:**
  - Macro undefined: waits for `data_ok`; `mem_wr`=1, `mem_wstrb`=4'b0011.
  - `ARB_WRITE_NOWAIT_EN` defined: DONE one cycle after `addr_ok`.
- **Reset mid-operation:** `rst` asserted in D_DATA, then a stray `data_ok` -> all outputs return to 0 and the FSM stays in IDLE.
